// File: rtl/zigzag_coef_serializer.sv
// Captures an 8x8 block of signed 8-bit coefficients, quantizes each by a rounding-toward-zero
// right shift, and streams them one per cycle in zig-zag order with valid/ready.
module zigzag_coef_serializer #(
  parameter int QSHIFT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         coef_valid,
  input  logic         coef_ready,
  output logic [7:0]   coef_data,
  output logic [5:0]   coef_idx,
  output logic         coef_last,
  output logic [5:0]   last_nz_idx,
  output logic         all_zero
);

  typedef enum logic {IDLE, STREAM} state_t;

  // Zig-zag position -> raster index {row, col}
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic signed [8:0] RND = 9'((1 << QSHIFT) - 1);

  // Negative values get a bias so the arithmetic shift rounds toward zero.
  function automatic logic [7:0] quant(input logic [7:0] v);
    logic signed [8:0] w;
    w = $signed({v[7], v});
    if (v[7]) w = w + RND;
    w = w >>> QSHIFT;
    return w[7:0];
  endfunction

  state_t            state_q, state_d;
  logic [63:0][7:0]  coef_buf_q, coef_buf_d;
  logic [63:0][7:0]  q_in;
  logic              coef_valid_q, coef_valid_d;
  logic [7:0]        coef_data_q, coef_data_d;
  logic [5:0]        coef_idx_q, coef_idx_d;
  logic              coef_last_q, coef_last_d;
  logic [5:0]        last_nz_q, last_nz_d;
  logic              all_zero_q, all_zero_d;
  logic [5:0]        nz_last;
  logic              nz_any;

  always_comb begin
    q_in    = '0;
    nz_last = '0;
    nz_any  = 1'b0;
    for (int i = 0; i < 64; i++)
      q_in[i] = quant(blk_data[64*(i/8) + 8*(7-(i%8)) +: 8]);
    for (int i = 0; i < 64; i++) begin
      if (q_in[ZZ[i]] != 8'd0) begin
        nz_last = 6'(i);
        nz_any  = 1'b1;
      end
    end

    state_d      = state_q;
    coef_buf_d   = coef_buf_q;
    coef_valid_d = coef_valid_q;
    coef_data_d  = coef_data_q;
    coef_idx_d   = coef_idx_q;
    coef_last_d  = coef_last_q;
    last_nz_d    = last_nz_q;
    all_zero_d   = all_zero_q;

    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          state_d      = STREAM;
          coef_buf_d   = q_in;
          last_nz_d    = nz_last;
          all_zero_d   = ~nz_any;
          coef_valid_d = 1'b1;
          coef_idx_d   = '0;
          coef_data_d  = q_in[ZZ[0]];
          coef_last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (coef_ready) begin
          if (coef_idx_q == 6'd63) begin
            state_d      = IDLE;
            coef_valid_d = 1'b0;
            coef_idx_d   = '0;
            coef_data_d  = '0;
            coef_last_d  = 1'b0;
          end else begin
            coef_idx_d  = coef_idx_q + 6'd1;
            coef_data_d = coef_buf_q[ZZ[coef_idx_q + 6'd1]];
            coef_last_d = (coef_idx_q == 6'd62);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      coef_buf_q   <= '0;
      coef_valid_q <= 1'b0;
      coef_data_q  <= '0;
      coef_idx_q   <= '0;
      coef_last_q  <= 1'b0;
      last_nz_q    <= '0;
      all_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      coef_buf_q   <= coef_buf_d;
      coef_valid_q <= coef_valid_d;
      coef_data_q  <= coef_data_d;
      coef_idx_q   <= coef_idx_d;
      coef_last_q  <= coef_last_d;
      last_nz_q    <= last_nz_d;
      all_zero_q   <= all_zero_d;
    end
  end

  assign blk_ready   = (state_q == IDLE) && !reset;
  assign coef_valid  = coef_valid_q;
  assign coef_data   = coef_data_q;
  assign coef_idx    = coef_idx_q;
  assign coef_last   = coef_last_q;
  assign last_nz_idx = last_nz_q;
  assign all_zero    = all_zero_q;

endmodule

// File: tb/tb_zigzag_coef_serializer.sv
// Directed bench: two serializer instances (QSHIFT 0 and 2) share inputs; expected streams are hand-built.
module tb_zigzag_coef_serializer;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         coef_ready = 1'b0;
  logic [511:0] blk_data = '0;

  logic r0, v0, l0, z0, r2, v2, l2, z2;
  logic [7:0] d0, d2;
  logic [5:0] i0, n0, i2, n2;

  int checks = 0;
  int errors = 0;

  int zz_tbl [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  logic [7:0] rast   [64];
  logic [7:0] exp_zz [64];

  zigzag_coef_serializer #(.QSHIFT(0)) u0 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(r0), .blk_data(blk_data),
    .coef_valid(v0), .coef_ready(coef_ready), .coef_data(d0), .coef_idx(i0),
    .coef_last(l0), .last_nz_idx(n0), .all_zero(z0));

  zigzag_coef_serializer #(.QSHIFT(2)) u2 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(r2), .blk_data(blk_data),
    .coef_valid(v2), .coef_ready(coef_ready), .coef_data(d2), .coef_idx(i2),
    .coef_last(l2), .last_nz_idx(n2), .all_zero(z2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack_blk();
    logic [511:0] b;
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[64*r + 8*(7-c) +: 8] = rast[8*r + c];
    return b;
  endfunction

  task automatic clear_rast();
    for (int i = 0; i < 64; i++) begin
      rast[i]   = 8'd0;
      exp_zz[i] = 8'd0;
    end
  endtask

  // Called at #1 after an edge while IDLE; returns at #1 after the capture edge.
  task automatic capture(input bit hold, input bit use2, input int exp_last, input bit exp_az);
    chk("blk_ready_idle", use2 ? r2 : r0, 1);
    blk_data  = pack_blk();
    blk_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) blk_valid = 1'b0;
    chk("last_nz_idx", use2 ? n2 : n0, exp_last);
    chk("all_zero", use2 ? z2 : z0, exp_az);
  endtask

  // Observes the stream against exp_zz; stall cycles must show the same coefficient again.
  task automatic run_stream(input bit use2, input bit rnd, input int stop_at, output int cyc);
    int n;
    bit rdy;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 1000) begin
      chk("coef_valid", use2 ? v2 : v0, 1);
      chk("coef_idx", use2 ? i2 : i0, n);
      chk("coef_data", use2 ? d2 : d0, exp_zz[n]);
      chk("coef_last", use2 ? l2 : l0, (n == 63));
      chk("blk_ready_stream", use2 ? r2 : r0, 0);
      if (n == stop_at) return;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) n++;
    end
    coef_ready = 1'b0;
    chk("stream_timeout", (cyc < 1000), 1);
    chk("coef_valid_after", use2 ? v2 : v0, 0);
    chk("blk_ready_after", use2 ? r2 : r0, 1);
  endtask

  initial begin
    int cyc;
    @(posedge clk); @(posedge clk); #1;
    // Reset values while reset is held
    chk("rst_blk_ready", r0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_idx", i0, 0);
    chk("rst_last", l0, 0);
    chk("rst_last_nz", n0, 0);
    chk("rst_all_zero", z0, 0);
    reset = 1'b0;
    #1;
    chk("rst_blk_ready_release", r0, 1);

    // 1: raster ramp, pass-through, full rate -> 64 stream cycles + 1 idle
    clear_rast();
    for (int i = 0; i < 64; i++) rast[i] = 8'(i);
    for (int i = 0; i < 64; i++) exp_zz[i] = 8'(zz_tbl[i]);
    capture(0, 0, 63, 0);
    run_stream(0, 0, -1, cyc);
    chk("t1_cycles", cyc, 64);
    #1;

    // 2: QSHIFT=2 row 0; (0,6)=4 quantizes to 1 at zz 27, so that is the last non-zero
    clear_rast();
    rast[0] = 8'hFB; rast[1] = 8'd5; rast[2] = 8'h80; rast[3] = 8'd127;
    rast[4] = 8'hFF; rast[5] = 8'd3; rast[6] = 8'd4;  rast[7] = 8'd0;
    exp_zz[0] = 8'hFF; exp_zz[1] = 8'd1; exp_zz[5] = 8'hE0; exp_zz[6] = 8'd31; exp_zz[27] = 8'd1;
    capture(0, 1, 27, 0);
    run_stream(1, 0, -1, cyc);

    // 3a: all-zero block
    clear_rast();
    capture(0, 0, 0, 1);
    chk("t3_u2_all_zero", z2, 1);
    chk("t3_u2_last_nz", n2, 0);
    run_stream(0, 0, -1, cyc);

    // 3b: single -1 at (7,7); QSHIFT=2 rounds it to zero
    clear_rast();
    rast[63] = 8'hFF;
    exp_zz[63] = 8'hFF;
    capture(0, 0, 63, 0);
    chk("t3b_u2_all_zero", z2, 1);
    run_stream(0, 0, -1, cyc);

    // 4: random back-pressure; blk_valid held with different data must not recapture
    clear_rast();
    for (int i = 0; i < 64; i++) rast[i] = 8'(i);
    for (int i = 0; i < 64; i++) exp_zz[i] = 8'(zz_tbl[i]);
    capture(1, 0, 63, 0);
    blk_data = {64{8'h55}};
    run_stream(0, 1, -1, cyc);
    blk_valid = 1'b0;
    chk("t4_last_nz_held", n0, 63);

    // 5: reset at idx 20, then a fresh block from idx 0
    capture(0, 0, 63, 0);
    run_stream(0, 0, 20, cyc);
    reset = 1'b1;
    coef_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid", v0, 0);
    chk("t5_idx", i0, 0);
    chk("t5_data", d0, 0);
    chk("t5_last", l0, 0);
    chk("t5_last_nz", n0, 0);
    chk("t5_blk_ready_in_rst", r0, 0);
    reset = 1'b0;
    coef_ready = 1'b0;
    #1;
    chk("t5_blk_ready", r0, 1);
    capture(0, 0, 63, 0);
    run_stream(0, 0, -1, cyc);

    // 6: back-to-back with blk_valid held: ramp, then reversed ramp 65 cycles later
    capture(1, 0, 63, 0);
    run_stream(0, 0, -1, cyc);
    for (int i = 0; i < 64; i++) rast[i] = 8'(63 - i);
    for (int i = 0; i < 64; i++) exp_zz[i] = 8'(63 - zz_tbl[i]);
    blk_data = pack_blk();
    @(posedge clk); #1;
    blk_valid = 1'b0;
    chk("t6_second_capture", v0, 1);
    chk("t6_last_nz", n0, 62);
    run_stream(0, 0, -1, cyc);
    chk("t6_cycles", cyc, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
